key_dispatcher: RTL and testbench

KEY_DISPATCHER -- requirements
Module: key_dispatcher

---
 rtl/rc4_crack_pkg.sv | 32 +++
 rtl/key_dispatcher_if.sv | 50 +++++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/key_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_key_dispatcher.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_crack_pkg.sv
// -----------------------------------------------------------------------------
// rc4_crack_pkg
// Shared definitions for the RC4 key-search dispatcher and its cracking cores.
//   KEY_W              width of an RC4 key candidate
//   BASE_W             width of the dispatch base counter (one extra bit so the
//                      counter can step past the last key without wrapping)
//   DEFAULT_BLOCK_BITS log2 of keys handed to a core per grant
//   DEFAULT_KEY_MAX    last key of the search space (inclusive)
//   state_e            one-hot dispatcher FSM states
//   block_step()       key increment between consecutive blocks
// -----------------------------------------------------------------------------
package rc4_crack_pkg;

  localparam int KEY_W  = 24;
  localparam int BASE_W = KEY_W + 1;

  localparam int              DEFAULT_BLOCK_BITS = 16;
  localparam logic [KEY_W-1:0] DEFAULT_KEY_MAX   = 24'h3FFFFF;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_DISPATCH = 5'b00010,
    ST_DRAIN    = 5'b00100,
    ST_FOUND    = 5'b01000,
    ST_NO_KEY   = 5'b10000
  } state_e;

  function automatic logic [BASE_W-1:0] block_step(input int block_bits);
    return BASE_W'(1) << block_bits;
  endfunction

endpackage

// File: rtl/key_dispatcher_if.sv
// -----------------------------------------------------------------------------
// key_dispatcher_if
// Bundles the control and core-facing signals of the key dispatcher.
//   master modport : the dispatcher (drives grants and status)
//   slave modport  : the controller/core side (drives start and core status)
// Signals:
//   start           one-cycle pulse, begin a search
//   core_req        per-core level, core idle and asking for a block
//   core_done       per-core pulse, block exhausted without a match
//   core_found      per-core pulse, match found, key on core_key
//   core_key        flat vector, core i's key at [KEY_W*i +: KEY_W]
//   grant           one-hot one-cycle block assignment
//   grant_base_key  first key of the granted block
//   abort           all cores stop searching
//   busy            search in progress
//   key_found       a key was found (LEDR0)
//   no_key          space exhausted without a match (LEDR1)
//   found_key       latched winning key
// -----------------------------------------------------------------------------
interface key_dispatcher_if
  import rc4_crack_pkg::*;
#(
  parameter int N_CORES = 4
);

  logic                       start;
  logic [N_CORES-1:0]         core_req;
  logic [N_CORES-1:0]         core_done;
  logic [N_CORES-1:0]         core_found;
  logic [KEY_W*N_CORES-1:0]   core_key;

  logic [N_CORES-1:0]         grant;
  logic [KEY_W-1:0]           grant_base_key;
  logic                       abort;
  logic                       busy;
  logic                       key_found;
  logic                       no_key;
  logic [KEY_W-1:0]           found_key;

  modport master (
    input  start, core_req, core_done, core_found, core_key,
    output grant, grant_base_key, abort, busy, key_found, no_key, found_key
  );

  modport slave (
    output start, core_req, core_done, core_found, core_key,
    input  grant, grant_base_key, abort, busy, key_found, no_key, found_key
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Searches req_i starting at the rotating pointer and
// returns a one-hot grant (combinational). When a grant is issued the pointer
// moves to the index after the winner, so every requester gets its turn.
//   clk, reset  clock, synchronous active-low reset (pointer -> 0)
//   req_i       request vector
//   en_i        arbitration enable; no grant and no pointer move when low
//   grant_o     one-hot grant, zero when disabled or nothing requested
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             hit;

  // NOTE: every signal assigned in always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    hit     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate index = (ptr + i) mod N without a divider.
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (en_i && !hit && req_i[idx]) begin
        hit          = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = (idx == PTR_W'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/key_dispatcher.sv
// -----------------------------------------------------------------------------
// key_dispatcher
// Hands out fixed-size blocks of the RC4 key space to N_CORES cracking cores,
// tracks which cores own a block, and reports either the winning key or that
// the whole space was searched without a match.
//   clk    sole clock, all logic on posedge
//   reset  synchronous, active-low
//   bus    key_dispatcher_if master modport (see interface header)
// Behaviour:
//   IDLE     wait for start; clear base counter and owner bitmap.
//   DISPATCH one round-robin grant per cycle to a requesting idle core; the
//            grant that pushes the base past KEY_MAX moves to DRAIN.
//   DRAIN    no grants; wait for every owner to report done.
//   FOUND    terminal; found_key holds the winning key.
//   NO_KEY   terminal; whole space exhausted.
// A found from an owning core beats done, grant and the NO_KEY exit.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module key_dispatcher
  import rc4_crack_pkg::*;
#(
  parameter int               N_CORES    = 4,
  parameter int               BLOCK_BITS = DEFAULT_BLOCK_BITS,
  parameter logic [KEY_W-1:0] KEY_MAX    = DEFAULT_KEY_MAX
) (
  input  logic             clk,
  input  logic             reset,
  key_dispatcher_if.master bus
);

  localparam logic [BASE_W-1:0] STEP  = block_step(BLOCK_BITS);
  localparam logic [BASE_W-1:0] LIMIT = {1'b0, KEY_MAX};

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   next_base_q, next_base_d;
  logic [N_CORES-1:0]  owner_q, owner_d;
  logic [N_CORES-1:0]  grant_q, grant_d;
  logic [KEY_W-1:0]    grant_base_q, grant_base_d;
  logic [KEY_W-1:0]    found_key_q, found_key_d;
  logic                abort_q, abort_d;
  logic                busy_q, busy_d;
  logic                key_found_q, key_found_d;
  logic                no_key_q, no_key_d;

  logic [N_CORES-1:0]  done_vld;
  logic [N_CORES-1:0]  found_vld;
  logic [N_CORES-1:0]  owner_freed;
  logic [N_CORES-1:0]  eligible;
  logic [N_CORES-1:0]  arb_grant;
  logic                arb_en;
  logic [KEY_W-1:0]    found_sel;
  logic [BASE_W-1:0]   next_base_inc;

  // Reports from cores that do not own a block are ignored.
  assign done_vld  = bus.core_done  & owner_q;
  assign found_vld = bus.core_found & owner_q;

  // Done is retired before arbitration so a core may finish and be re-granted
  // in the same cycle.
  assign owner_freed   = owner_q & ~done_vld;
  assign eligible      = bus.core_req & ~owner_freed;
  assign arb_en        = (state_q == ST_DISPATCH) && (found_vld == '0);
  assign next_base_inc = next_base_q + STEP;

  rr_arbiter #(
    .N (N_CORES)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (eligible),
    .en_i    (arb_en),
    .grant_o (arb_grant)
  );

  // Lowest-index winner: scan downward so the lowest hit is written last.
  always_comb begin
    found_sel = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (found_vld[i]) begin
        found_sel = bus.core_key[KEY_W*i +: KEY_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    owner_d      = owner_q;
    grant_d      = '0;
    grant_base_d = '0;
    found_key_d  = found_key_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_DISPATCH;
          next_base_d = '0;
          owner_d     = '0;
        end
      end

      ST_DISPATCH: begin
        if (found_vld != '0) begin
          state_d     = ST_FOUND;
          found_key_d = found_sel;
        end else begin
          owner_d = owner_freed;
          if (arb_grant != '0) begin
            grant_d      = arb_grant;
            grant_base_d = next_base_q[KEY_W-1:0];
            owner_d      = owner_freed | arb_grant;
            next_base_d  = next_base_inc;
            if (next_base_inc > LIMIT) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (found_vld != '0) begin
          state_d     = ST_FOUND;
          found_key_d = found_sel;
        end else begin
          owner_d = owner_freed;
          if (owner_freed == '0) begin
            state_d = ST_NO_KEY;
          end
        end
      end

      ST_FOUND, ST_NO_KEY: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags follow the next state so they line up with state_q.
    busy_d      = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
    abort_d     = (state_d == ST_FOUND) || (state_d == ST_NO_KEY);
    key_found_d = (state_d == ST_FOUND);
    no_key_d    = (state_d == ST_NO_KEY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      next_base_q  <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      grant_base_q <= '0;
      found_key_q  <= '0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      key_found_q  <= 1'b0;
      no_key_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_base_q  <= next_base_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      grant_base_q <= grant_base_d;
      found_key_q  <= found_key_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      key_found_q  <= key_found_d;
      no_key_q     <= no_key_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.grant_base_key = grant_base_q;
  assign bus.found_key      = found_key_q;
  assign bus.abort          = abort_q;
  assign bus.busy           = busy_q;
  assign bus.key_found      = key_found_q;
  assign bus.no_key         = no_key_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_key_dispatcher
// Directed bench for key_dispatcher (4 cores, 64K-key blocks, 4M-key space).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_key_dispatcher;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  key_dispatcher_if #(.N_CORES(N)) bus ();

  key_dispatcher #(
    .N_CORES    (N),
    .BLOCK_BITS (16),
    .KEY_MAX    (24'h3FFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.core_req   = '0;
    bus.core_done  = '0;
    bus.core_found = '0;
    bus.core_key   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] gb;
    logic [27:0] fl;
    clear_inputs();
    reset = 1'b0;
    tick();
    gb = {bus.grant, bus.grant_base_key};
    fl = {bus.abort, bus.busy, bus.key_found, bus.no_key, bus.found_key};
    vectors++;
    if (gb !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_grant got %h want 0", gb);
    end
    vectors++;
    if (fl !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_flags got %h want 0", fl);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_hold got busy=%b grant=%b want 0/0000", bus.busy, bus.grant);
    end
  endtask

  task automatic test_dispatch_order();
    logic [3:0]  exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [23:0] exp_b [4] = '{24'h000000, 24'h010000, 24'h020000, 24'h030000};
    do_reset();
    bus.core_req = 4'b1111;
    pulse_start();
    vectors++;
    if (bus.busy !== 1'b1 || bus.grant !== 4'b0) begin
      miscompares++;
      $display("FAIL start_dispatch got busy=%b grant=%b want 1/0000", bus.busy, bus.grant);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.grant !== exp_g[i] || bus.grant_base_key !== exp_b[i]) begin
        miscompares++;
        $display("FAIL order_grant%0d got %b/%h want %b/%h", i, bus.grant,
                 bus.grant_base_key, exp_g[i], exp_b[i]);
      end
    end
    tick();
    vectors++;
    if (bus.grant !== 4'b0 || bus.grant_base_key !== 24'h0) begin
      miscompares++;
      $display("FAIL all_owned got %b/%h want 0000/000000", bus.grant, bus.grant_base_key);
    end
  endtask

  // Every core finishes its block the cycle after the grant and keeps
  // requesting, so one grant per cycle rotates through the cores.
  task automatic sweep_to_drain(input bit check_bases);
    logic [3:0]  prev;
    logic [3:0]  eg;
    logic [23:0] eb;
    int          n;
    do_reset();
    bus.core_req = 4'b1111;
    pulse_start();
    prev = '0;
    n    = 0;
    for (int cyc = 0; cyc < 200 && n < 64; cyc++) begin
      bus.core_done = prev;
      tick();
      prev = bus.grant;
      if (bus.grant !== 4'b0) begin
        if (check_bases) begin
          eg = 4'b0001 << (n % 4);
          eb = 24'(n) << 16;
          vectors++;
          if (bus.grant !== eg || bus.grant_base_key !== eb) begin
            miscompares++;
            $display("FAIL sweep_grant%0d got %b/%h want %b/%h", n, bus.grant,
                     bus.grant_base_key, eg, eb);
          end
        end
        n++;
      end
    end
    bus.core_done = '0;
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL sweep_count got %0d want 64", n);
    end
  endtask

  task automatic test_full_sweep();
    sweep_to_drain(1'b1);
    tick();
    vectors++;
    if (bus.grant !== 4'b0 || bus.busy !== 1'b1 || bus.no_key !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_hold got grant=%b busy=%b no_key=%b want 0000/1/0",
               bus.grant, bus.busy, bus.no_key);
    end
    bus.core_done = 4'b1000;
    tick();
    bus.core_done = '0;
    vectors++;
    if ({bus.no_key, bus.abort, bus.busy, bus.key_found} !== 4'b1100) begin
      miscompares++;
      $display("FAIL no_key_exit got nk/ab/bz/kf=%b%b%b%b want 1100",
               bus.no_key, bus.abort, bus.busy, bus.key_found);
    end
    pulse_start();
    tick();
    vectors++;
    if (bus.no_key !== 1'b1 || bus.busy !== 1'b0 || bus.grant !== 4'b0) begin
      miscompares++;
      $display("FAIL no_key_terminal got nk=%b busy=%b grant=%b want 1/0/0000",
               bus.no_key, bus.busy, bus.grant);
    end
  endtask

  task automatic test_found_dispatch();
    do_reset();
    bus.core_req = 4'b1111;
    pulse_start();
    tick();
    tick();
    tick();
    bus.core_found = 4'b0100;
    bus.core_key[2*24 +: 24] = 24'h1A2B3C;
    tick();
    bus.core_found = '0;
    vectors++;
    if (bus.key_found !== 1'b1 || bus.found_key !== 24'h1A2B3C || bus.abort !== 1'b1) begin
      miscompares++;
      $display("FAIL found_dispatch got kf=%b key=%h abort=%b want 1/1a2b3c/1",
               bus.key_found, bus.found_key, bus.abort);
    end
    vectors++;
    if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL found_no_grant got grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.grant !== 4'b0 || bus.found_key !== 24'h1A2B3C) begin
        miscompares++;
        $display("FAIL found_hold%0d got grant=%b key=%h want 0000/1a2b3c",
                 i, bus.grant, bus.found_key);
      end
    end
  endtask

  task automatic test_found_priority();
    do_reset();
    bus.core_req = 4'b1111;
    pulse_start();
    repeat (4) tick();
    bus.core_req = '0;
    bus.core_key = {24'h333333, 24'h222222, 24'h111111, 24'hDEAD00};
    bus.core_found = 4'b1010;
    tick();
    bus.core_found = '0;
    vectors++;
    if (bus.key_found !== 1'b1 || bus.found_key !== 24'h111111) begin
      miscompares++;
      $display("FAIL found_lowest got kf=%b key=%h want 1/111111", bus.key_found, bus.found_key);
    end
  endtask

  task automatic test_found_vs_drain();
    sweep_to_drain(1'b0);
    bus.core_done  = 4'b1000;
    bus.core_found = 4'b1000;
    bus.core_key[3*24 +: 24] = 24'h3F1234;
    tick();
    bus.core_done  = '0;
    bus.core_found = '0;
    vectors++;
    if ({bus.key_found, bus.no_key, bus.abort} !== 3'b101 || bus.found_key !== 24'h3F1234) begin
      miscompares++;
      $display("FAIL found_beats_drain got kf/nk/ab=%b%b%b key=%h want 101/3f1234",
               bus.key_found, bus.no_key, bus.abort, bus.found_key);
    end
  endtask

  // Sparse requests exercise the rotating pointer; reports from cores that
  // own nothing must not end the search.
  task automatic test_rr_sparse();
    logic [3:0]  exp_g [3] = '{4'b1000, 4'b0001, 4'b0010};
    logic [23:0] exp_b [3] = '{24'h010000, 24'h020000, 24'h030000};
    do_reset();
    pulse_start();
    bus.core_req = 4'b0100;
    tick();
    vectors++;
    if (bus.grant !== 4'b0100 || bus.grant_base_key !== 24'h000000) begin
      miscompares++;
      $display("FAIL rr_first got %b/%h want 0100/000000", bus.grant, bus.grant_base_key);
    end
    bus.core_req   = '0;
    bus.core_found = 4'b0001;
    bus.core_done  = 4'b0010;
    bus.core_key   = {4{24'hABCDEF}};
    tick();
    bus.core_found = '0;
    bus.core_done  = '0;
    vectors++;
    if (bus.key_found !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 4'b0) begin
      miscompares++;
      $display("FAIL unowned_ignored got kf=%b busy=%b grant=%b want 0/1/0000",
               bus.key_found, bus.busy, bus.grant);
    end
    bus.core_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.grant !== exp_g[i] || bus.grant_base_key !== exp_b[i]) begin
        miscompares++;
        $display("FAIL rr_grant%0d got %b/%h want %b/%h", i, bus.grant,
                 bus.grant_base_key, exp_g[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [55:0] all;
    do_reset();
    bus.core_req = 4'b1111;
    pulse_start();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    all = {bus.grant, bus.grant_base_key, bus.abort, bus.busy, bus.key_found,
           bus.no_key, bus.found_key};
    vectors++;
    if (all !== 56'h0) begin
      miscompares++;
      $display("FAIL mid_reset got %h want 0", all);
    end
    pulse_start();
    tick();
    vectors++;
    if (bus.grant !== 4'b0001 || bus.grant_base_key !== 24'h000000) begin
      miscompares++;
      $display("FAIL restart_base got %b/%h want 0001/000000", bus.grant, bus.grant_base_key);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_dispatch_order();
    test_full_sweep();
    test_found_dispatch();
    test_found_priority();
    test_found_vs_drain();
    test_rr_sparse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
